// File: rtl/spi_regfile_slave.sv
// spi_regfile_slave -- SPI mode-0 slave register file clocked only by SCLK.
//
// Frame: 1 R/Wn bit (1 = read), ADDR_W address bits, then DATA_W data bits,
// all MSB first. MOSI is sampled on posedge SCLK; MISO is launched on negedge.
// Reads of LIVE_BASE..LIVE_BASE+NUM_LIVE-1 return a snapshot of live_data
// taken when the response word is loaded; writes there are dropped.
//
// Optional feature: define SPI_BURST_EN to keep the frame in the data phase
// after each word with the address auto-incrementing (mod 2**ADDR_W).
// Without it, a frame carries exactly one data word and later SCLKs are ignored.
//
// Ports:
//   SCLK          serial clock, idle low
//   rst_n         asynchronous active-low reset (clears everything)
//   SS_n          active-low select; while high the frame logic is held clear
//   MOSI          serial data in
//   MISO          serial data out, high-Z while SS_n=1
//   live_data     NUM_LIVE packed live words, word i at [i*DATA_W +: DATA_W]
//   live_rd_strb  one-SCLK pulse when a live word is loaded for a read
//   live_rd_idx   index of that live word
//   cfg_valid     both configuration registers hold their expected values
module spi_regfile_slave #(
  parameter int unsigned        ADDR_W    = 7,
  parameter int unsigned        DATA_W    = 8,
  parameter int unsigned        NUM_LIVE  = 4,
  parameter int unsigned        LIVE_BASE = 'h22,
  parameter logic [DATA_W-1:0]  WR_RESP   = 8'hA5,
  parameter int unsigned        CFG_ADDR0 = 'h0D,
  parameter logic [DATA_W-1:0]  CFG_VAL0  = 8'h02,
  parameter int unsigned        CFG_ADDR1 = 'h11,
  parameter logic [DATA_W-1:0]  CFG_VAL1  = 8'h50,
  localparam int unsigned       IDX_W     = (NUM_LIVE > 1) ? $clog2(NUM_LIVE) : 1
) (
  input  logic                       SCLK,
  input  logic                       rst_n,
  input  logic                       SS_n,
  input  logic                       MOSI,
  output logic                       MISO,
  input  logic [NUM_LIVE*DATA_W-1:0] live_data,
  output logic                       live_rd_strb,
  output logic [IDX_W-1:0]           live_rd_idx,
  output logic                       cfg_valid
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  // rx only needs to hold the bits preceding the one on MOSI at the last edge
  localparam int unsigned RX_W  = (ADDR_W > DATA_W-1) ? ADDR_W : DATA_W-1;
  localparam int unsigned CNT_W = $clog2(ADDR_W + DATA_W + 1);

  typedef enum logic [1:0] {PH_CMD, PH_DATA, PH_DONE} phase_t;

  phase_t             phase, phase_nxt;
  logic [CNT_W-1:0]   bit_cnt, cnt_nxt;
  logic [RX_W-1:0]    rx;
  logic               rw, rw_nxt;
  logic [ADDR_W-1:0]  addr, addr_nxt;
  logic               word_last;
  logic               frame_clr;

  logic [DATA_W-1:0]  regs [DEPTH];
  logic [DATA_W-1:0]  tx;
  logic [DATA_W-1:0]  resp;
  logic               load;
  logic               wr_commit;

  logic [31:0]        addr_ext;
  logic               addr_live;
  logic [IDX_W-1:0]   addr_idx;
  logic [DATA_W-1:0]  live_word;

  logic               strb_q;
  logic [IDX_W-1:0]   idx_q;

  // Frame state is cleared by either reset or deselect.
  assign frame_clr = ~rst_n | SS_n;

  // ---------------- live window decode ----------------
  assign addr_ext  = 32'(addr);
  assign addr_live = (addr_ext >= LIVE_BASE) && (addr_ext < LIVE_BASE + NUM_LIVE);
  assign addr_idx  = IDX_W'(addr_ext - LIVE_BASE);
  assign live_word = live_data[addr_idx*DATA_W +: DATA_W];

  // ---------------- phase FSM ----------------
  always_ff @(posedge SCLK or posedge frame_clr) begin
    if (frame_clr) begin
      phase   <= PH_CMD;
      bit_cnt <= '0;
      rx      <= '0;
      rw      <= 1'b0;
      addr    <= '0;
    end else begin
      phase   <= phase_nxt;
      bit_cnt <= cnt_nxt;
      rx      <= {rx[RX_W-2:0], MOSI};
      rw      <= rw_nxt;
      addr    <= addr_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = bit_cnt + 1'b1;
    rw_nxt    = rw;
    addr_nxt  = addr;
    word_last = 1'b0;
    case (phase)
      PH_CMD: begin
        // the R/Wn bit has already reached rx[ADDR_W-1] by the last address bit
        if (bit_cnt == CNT_W'(ADDR_W)) begin
          phase_nxt = PH_DATA;
          cnt_nxt   = '0;
          rw_nxt    = rx[ADDR_W-1];
          addr_nxt  = {rx[ADDR_W-2:0], MOSI};
        end
      end
      PH_DATA: begin
        if (bit_cnt == CNT_W'(DATA_W-1)) begin
          word_last = 1'b1;
          cnt_nxt   = '0;
`ifdef SPI_BURST_EN
          addr_nxt  = addr + 1'b1;
`else
          phase_nxt = PH_DONE;
`endif
        end
      end
      default: cnt_nxt = bit_cnt;
    endcase
  end

  // ---------------- register array ----------------
  assign wr_commit = word_last && !rw && !addr_live;

  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_commit) begin
      regs[addr] <= {rx[DATA_W-2:0], MOSI};
    end
  end

  assign cfg_valid = (regs[ADDR_W'(CFG_ADDR0)] == CFG_VAL0) &&
                     (regs[ADDR_W'(CFG_ADDR1)] == CFG_VAL1);

  // ---------------- response path (negedge) ----------------
  // bit_cnt==0 in DATA marks the half-cycle right after a word boundary,
  // i.e. the negedge that must present the next response word.
  assign load = (phase == PH_DATA) && (bit_cnt == '0);

  always_comb begin
    resp = WR_RESP;
    if (rw) resp = addr_live ? live_word : regs[addr];
  end

  always_ff @(negedge SCLK or posedge frame_clr) begin
    if (frame_clr) begin
      tx     <= '0;
      strb_q <= 1'b0;
    end else if (load) begin
      tx     <= resp;
      strb_q <= rw && addr_live;
    end else begin
      tx     <= (phase == PH_DATA) ? {tx[DATA_W-2:0], 1'b0} : '0;
      strb_q <= 1'b0;
    end
  end

  // index holds its last value between reads
  always_ff @(negedge SCLK or negedge rst_n) begin
    if (!rst_n)                          idx_q <= '0;
    else if (load && rw && addr_live)    idx_q <= addr_idx;
  end

  assign live_rd_strb = strb_q;
  assign live_rd_idx  = idx_q;
  assign MISO         = SS_n ? 1'bz : tx[DATA_W-1];

endmodule
